// File: rtl/ex_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared types for the execution writeback collection stage.
//
// Contents:
//   DEF_R_ADDR / DEF_ROB_INDEX_BITS / DEF_CAUSE_W : default field widths.
//   wb_entry_t : one buffered functional-unit result (data, dest, ticket,
//                exc, cause). Its field widths follow the defaults above.
//   wrapIncr   : increment an index modulo an arbitrary (non power of 2)
//                modulus.
// ---------------------------------------------------------------------------
package ex_pkg;

  localparam int DEF_R_ADDR         = 6;
  localparam int DEF_ROB_INDEX_BITS = 3;
  localparam int DEF_CAUSE_W        = 4;

  // One result as it travels from a functional unit to the ROB/RF.
  typedef struct packed {
    logic [31:0]                   data;
    logic [DEF_R_ADDR-1:0]         dest;
    logic [DEF_ROB_INDEX_BITS-1:0] ticket;
    logic                          exc;
    logic [DEF_CAUSE_W-1:0]        cause;
  } wb_entry_t;

  // Next index after idx, wrapping to 0 at modulus.
  function automatic int unsigned wrapIncr(input int unsigned idx,
                                           input int unsigned modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ex_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ex_wb_arbiter_if
// Bundle of the functional-unit result channels and the writeback buses.
//
// Signals (widths follow the parameters):
//   fu_valid/fu_ready/fu_data/fu_dest/fu_ticket/fu_exc/fu_cause : FU side,
//     FU i occupies slice i of every packed vector.
//   wb_valid/wb_data/wb_dest/wb_ticket/wb_exc/wb_cause/wb_fu_id : writeback
//     side, port p occupies slice p.
//   perf_stall_cnt : 16-bit refused-push counter per FU.
//
// Modports:
//   master : the functional units / environment (drives fu_*).
//   slave  : the arbiter (drives fu_ready, wb_*, perf_stall_cnt).
// ---------------------------------------------------------------------------
interface ex_wb_arbiter_if #(
  parameter int FU_NUMBER      = 4,
  parameter int WB_PORTS       = 2,
  parameter int R_ADDR         = 6,
  parameter int ROB_INDEX_BITS = 3,
  parameter int CAUSE_W        = 4
);

  localparam int FU_ID_W = $clog2(FU_NUMBER);

  logic [FU_NUMBER-1:0]                fu_valid;
  logic [FU_NUMBER-1:0]                fu_ready;
  logic [FU_NUMBER*32-1:0]             fu_data;
  logic [FU_NUMBER*R_ADDR-1:0]         fu_dest;
  logic [FU_NUMBER*ROB_INDEX_BITS-1:0] fu_ticket;
  logic [FU_NUMBER-1:0]                fu_exc;
  logic [FU_NUMBER*CAUSE_W-1:0]        fu_cause;

  logic [WB_PORTS-1:0]                 wb_valid;
  logic [WB_PORTS*32-1:0]              wb_data;
  logic [WB_PORTS*R_ADDR-1:0]          wb_dest;
  logic [WB_PORTS*ROB_INDEX_BITS-1:0]  wb_ticket;
  logic [WB_PORTS-1:0]                 wb_exc;
  logic [WB_PORTS*CAUSE_W-1:0]         wb_cause;
  logic [WB_PORTS*FU_ID_W-1:0]         wb_fu_id;

  logic [FU_NUMBER*16-1:0]             perf_stall_cnt;

  modport master (
    output fu_valid, fu_data, fu_dest, fu_ticket, fu_exc, fu_cause,
    input  fu_ready,
    input  wb_valid, wb_data, wb_dest, wb_ticket, wb_exc, wb_cause, wb_fu_id,
    input  perf_stall_cnt
  );

  modport slave (
    input  fu_valid, fu_data, fu_dest, fu_ticket, fu_exc, fu_cause,
    output fu_ready,
    output wb_valid, wb_data, wb_dest, wb_ticket, wb_exc, wb_cause, wb_fu_id,
    output perf_stall_cnt
  );

endinterface

// File: rtl/ex_wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// ex_wb_fifo
// Single-clock FIFO of wb_entry_t used as the per-FU result buffer.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset.
//   i_flush        : synchronous empty; overrides push and pop that cycle.
//   i_push, i_data : write i_data when not full.
//   i_pop          : drop the head entry when not empty.
//   o_head         : current head entry (valid when !o_empty).
//   o_count        : number of stored entries (0..DEPTH).
//   o_full/o_empty : status flags.
//
// Pointers carry one extra wrap bit so that full and empty are told apart
// without a separate counter.
// ---------------------------------------------------------------------------
module ex_wb_fifo
  import ex_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  wb_entry_t         i_data,
  input  logic              i_pop,
  output wb_entry_t         o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] r_wrPtr;
  logic [PTR_W:0] r_rdPtr;
  wb_entry_t      r_mem [DEPTH];
  logic           w_doPush;
  logic           w_doPop;

  // Full when the wrap bits differ but the addresses match; empty when the
  // whole pointers are equal.
  assign o_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                   (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_count = r_wrPtr - r_rdPtr;
  assign o_head  = r_mem[r_rdPtr[PTR_W-1:0]];

  // A full FIFO refuses a push even when it pops in the same cycle, so the
  // producer's ready never depends on the consumer side.
  assign w_doPush = i_push & ~o_full  & ~i_flush;
  assign w_doPop  = i_pop  & ~o_empty & ~i_flush;

  // Pointer update: flush snaps both pointers back to the empty state,
  // otherwise each side advances independently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so it carries no
  // reset and maps onto plain registers or a small RAM.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/ex_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ex_wb_arbiter
// Writeback collection stage behind the execution functional units. Every
// FU result is buffered in its own FIFO; up to WB_PORTS heads per cycle are
// selected round-robin and registered onto the writeback buses.
//
// Ports:
//   clk   : clock.
//   rst_n : asynchronous active-low reset (empties everything, outputs 0).
//   flush : synchronous squash of buffered and outgoing results.
//   bus   : ex_wb_arbiter_if.slave - FU result channels, writeback buses
//           and per-FU stall counters.
//
// Optional feature macro: EX_WB_PERF_CNT_EN
//   defined   -> per-FU saturating 16-bit counters of cycles where the FU
//                was valid but its FIFO refused the push; cleared by reset.
//   undefined -> perf_stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module ex_wb_arbiter
  import ex_pkg::*;
#(
  parameter int FU_NUMBER      = 4,
  parameter int WB_PORTS       = 2,
  parameter int DEPTH          = 4,
  parameter int R_ADDR         = DEF_R_ADDR,
  parameter int ROB_INDEX_BITS = DEF_ROB_INDEX_BITS,
  parameter int CAUSE_W        = DEF_CAUSE_W
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  ex_wb_arbiter_if.slave  bus
);

  localparam int FU_ID_W = $clog2(FU_NUMBER);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  wb_entry_t            w_pushEntry [FU_NUMBER];
  wb_entry_t            w_head      [FU_NUMBER];
  logic [CNT_W-1:0]     w_count     [FU_NUMBER];
  logic [FU_NUMBER-1:0] w_full;
  logic [FU_NUMBER-1:0] w_empty;
  logic [FU_NUMBER-1:0] w_ready;
  logic [FU_NUMBER-1:0] w_push;
  logic [FU_NUMBER-1:0] w_pop;

  logic [WB_PORTS-1:0]  w_grantValid;
  logic [FU_ID_W-1:0]   w_grantSel  [WB_PORTS];
  logic [FU_ID_W-1:0]   w_lastIdx;
  logic [FU_ID_W-1:0]   w_rrNext;
  logic                 w_anyGrant;

  logic [FU_ID_W-1:0]   r_rrPtr;
  logic [WB_PORTS-1:0]  r_wbValid;
  wb_entry_t            r_wbEntry   [WB_PORTS];
  logic [FU_ID_W-1:0]   r_wbFuId    [WB_PORTS];

  // Ready comes only from the stored count, never from this cycle's pop.
  assign bus.fu_ready = w_ready;
  assign w_push       = bus.fu_valid & ~w_full & ~{FU_NUMBER{flush}};

  // Per-FU input packing and result buffer. Tags are cast to the entry
  // widths so a differently sized tag bus still elaborates.
  for (genvar i = 0; i < FU_NUMBER; i++) begin : g_fu
    assign w_pushEntry[i] = '{
      data:   bus.fu_data[32*i +: 32],
      dest:   DEF_R_ADDR'(bus.fu_dest[R_ADDR*i +: R_ADDR]),
      ticket: DEF_ROB_INDEX_BITS'(bus.fu_ticket[ROB_INDEX_BITS*i +: ROB_INDEX_BITS]),
      exc:    bus.fu_exc[i],
      cause:  DEF_CAUSE_W'(bus.fu_cause[CAUSE_W*i +: CAUSE_W])
    };

    assign w_ready[i] = (w_count[i] < CNT_W'(DEPTH));

    ex_wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_flush (flush),
      .i_push  (w_push[i]),
      .i_data  (w_pushEntry[i]),
      .i_pop   (w_pop[i]),
      .o_head  (w_head[i]),
      .o_count (w_count[i]),
      .o_full  (w_full[i]),
      .o_empty (w_empty[i])
    );
  end

  // Round-robin grant: walk the FU indices starting at r_rrPtr and hand
  // each non-empty FIFO the lowest still-free writeback port. Because every
  // FU is visited once, no FU can win more than one port per cycle.
  always_comb begin
    int unsigned scanSum;
    logic [FU_ID_W-1:0] scanIdx;
    logic placed;
    w_pop        = '0;
    w_grantValid = '0;
    w_lastIdx    = r_rrPtr;
    scanSum      = 0;
    scanIdx      = '0;
    placed       = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) w_grantSel[p] = '0;
    for (int k = 0; k < FU_NUMBER; k++) begin
      scanSum = 32'(r_rrPtr) + 32'(k);
      if (scanSum >= 32'(FU_NUMBER)) scanSum = scanSum - 32'(FU_NUMBER);
      scanIdx = FU_ID_W'(scanSum);
      placed  = 1'b0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (!placed && !w_grantValid[p] && !w_empty[scanIdx]) begin
          w_grantValid[p] = 1'b1;
          w_grantSel[p]   = scanIdx;
          w_pop[scanIdx]  = 1'b1;
          w_lastIdx       = scanIdx;
          placed          = 1'b1;
        end
      end
    end
  end

  // The next scan starts just after the last FU that won a port.
  assign w_anyGrant = |w_grantValid;
  assign w_rrNext   = FU_ID_W'(wrapIncr(32'(w_lastIdx), FU_NUMBER));

  // Writeback registers and round-robin pointer. Ports that win nothing
  // drop valid but keep their payload fields, which saves enables on the
  // wide data path. Flush kills this cycle's grants and restarts the scan
  // at FU 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr   <= '0;
      r_wbValid <= '0;
      for (int p = 0; p < WB_PORTS; p++) begin
        r_wbEntry[p] <= '0;
        r_wbFuId[p]  <= '0;
      end
    end else if (flush) begin
      r_rrPtr   <= '0;
      r_wbValid <= '0;
    end else begin
      r_wbValid <= w_grantValid;
      if (w_anyGrant) r_rrPtr <= w_rrNext;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (w_grantValid[p]) begin
          r_wbEntry[p] <= w_head[w_grantSel[p]];
          r_wbFuId[p]  <= w_grantSel[p];
        end
      end
    end
  end

  // Flatten the registered ports onto the packed writeback buses.
  assign bus.wb_valid = r_wbValid;
  for (genvar p = 0; p < WB_PORTS; p++) begin : g_port
    assign bus.wb_data[32*p +: 32]                         = r_wbEntry[p].data;
    assign bus.wb_dest[R_ADDR*p +: R_ADDR]                 = R_ADDR'(r_wbEntry[p].dest);
    assign bus.wb_ticket[ROB_INDEX_BITS*p +: ROB_INDEX_BITS] = ROB_INDEX_BITS'(r_wbEntry[p].ticket);
    assign bus.wb_exc[p]                                   = r_wbEntry[p].exc;
    assign bus.wb_cause[CAUSE_W*p +: CAUSE_W]              = CAUSE_W'(r_wbEntry[p].cause);
    assign bus.wb_fu_id[FU_ID_W*p +: FU_ID_W]              = r_wbFuId[p];
  end

`ifdef EX_WB_PERF_CNT_EN
  // Stall counters: one count per cycle in which an FU offered a result
  // that its full FIFO turned away. They stick at all-ones and survive
  // flush so that long profiling windows are not disturbed by squashes.
  for (genvar i = 0; i < FU_NUMBER; i++) begin : g_perf
    logic [15:0] r_stallCnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stallCnt <= '0;
      end else if (bus.fu_valid[i] && !w_ready[i] && (r_stallCnt != 16'hFFFF)) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
    end
    assign bus.perf_stall_cnt[16*i +: 16] = r_stallCnt;
  end
`else
  assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ex_wb_arbiter
// Directed bench for ex_wb_arbiter (4 FUs, 2 writeback ports, depth 4).
// A queue-per-FU reference tracks what must come out of each port; a few
// hand-computed spot checks pin down the exact cycle-level behaviour.
// ---------------------------------------------------------------------------
module tb_ex_wb_arbiter;

  localparam int FU  = 4;
  localparam int WB  = 2;
  localparam int DP  = 4;
  localparam int RA  = 6;
  localparam int RT  = 3;
  localparam int CW  = 4;
  localparam int IDW = 2;
  localparam int EW  = 32 + RA + RT + 1 + CW;

  typedef logic [EW-1:0] entQ_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  ex_wb_arbiter_if #(
    .FU_NUMBER(FU), .WB_PORTS(WB), .R_ADDR(RA),
    .ROB_INDEX_BITS(RT), .CAUSE_W(CW)
  ) bus ();

  ex_wb_arbiter #(
    .FU_NUMBER(FU), .WB_PORTS(WB), .DEPTH(DP), .R_ADDR(RA),
    .ROB_INDEX_BITS(RT), .CAUSE_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  entQ_t       modelQ [FU];
  int          modelRr;
  int unsigned modelStall [FU];
  int          testCount;
  int          failCount;
  int          stimTag;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [EW-1:0] fuEntry(input int i);
    return {bus.fu_data[32*i +: 32], bus.fu_dest[RA*i +: RA],
            bus.fu_ticket[RT*i +: RT], bus.fu_exc[i], bus.fu_cause[CW*i +: CW]};
  endfunction

  function automatic logic [EW-1:0] wbEntry(input int p);
    return {bus.wb_data[32*p +: 32], bus.wb_dest[RA*p +: RA],
            bus.wb_ticket[RT*p +: RT], bus.wb_exc[p], bus.wb_cause[CW*p +: CW]};
  endfunction

  task automatic setFu(input int i, input logic [31:0] d, input logic [RA-1:0] dst,
                       input logic [RT-1:0] tk, input logic e, input logic [CW-1:0] c);
    bus.fu_data[32*i +: 32]  = d;
    bus.fu_dest[RA*i +: RA]  = dst;
    bus.fu_ticket[RT*i +: RT] = tk;
    bus.fu_exc[i]            = e;
    bus.fu_cause[CW*i +: CW] = c;
  endtask

  task automatic clearModel();
    for (int i = 0; i < FU; i++) begin
      modelQ[i].delete();
      modelStall[i] = 0;
    end
    modelRr = 0;
  endtask

  // One clock with the inputs already on the bus: check ready before the
  // edge, advance the reference, then check the registered ports after it.
  task automatic runCycle();
    logic [FU-1:0] readyModel;
    logic [WB-1:0] expValid;
    logic [EW-1:0] expEnt [WB];
    int            expFu  [WB];
    int            n;
    int            last;
    int            idx;
    @(negedge clk);
    for (int i = 0; i < FU; i++) begin
      readyModel[i] = (modelQ[i].size() < DP);
      checkOutput("fuReady", 64'(bus.fu_ready[i]), 64'(readyModel[i]));
      if (bus.fu_valid[i] && !readyModel[i] && modelStall[i] != 32'hFFFF)
        modelStall[i]++;
    end
    expValid = '0;
    n = 0;
    last = 0;
    for (int p = 0; p < WB; p++) begin
      expEnt[p] = '0;
      expFu[p]  = 0;
    end
    if (flush) begin
      for (int i = 0; i < FU; i++) modelQ[i].delete();
      modelRr = 0;
    end else begin
      for (int k = 0; k < FU; k++) begin
        idx = (modelRr + k) % FU;
        if (n < WB && modelQ[idx].size() > 0) begin
          expEnt[n]   = modelQ[idx].pop_front();
          expFu[n]    = idx;
          expValid[n] = 1'b1;
          last        = idx;
          n++;
        end
      end
      if (n > 0) modelRr = (last + 1) % FU;
      for (int i = 0; i < FU; i++)
        if (bus.fu_valid[i] && readyModel[i]) modelQ[i].push_back(fuEntry(i));
    end
    @(posedge clk);
    #1;
    checkOutput("wbValid", 64'(bus.wb_valid), 64'(expValid));
    for (int p = 0; p < WB; p++) begin
      if (expValid[p]) begin
        checkOutput("wbFuId", 64'(bus.wb_fu_id[IDW*p +: IDW]), 64'(expFu[p]));
        checkOutput("wbEntry", 64'(wbEntry(p)), 64'(expEnt[p]));
      end
    end
  endtask

  // Drive a fresh, distinct payload on every FU plus the valid mask and
  // flush, then clock once.
  task automatic applyStimulus(input logic [FU-1:0] valid, input logic fl);
    for (int i = 0; i < FU; i++) begin
      setFu(i, {8'(i), 24'(stimTag)}, RA'(stimTag + 7 * i), RT'(stimTag + i),
            stimTag[0] ^ i[0], CW'(3 * stimTag + i));
    end
    stimTag++;
    bus.fu_valid = valid;
    flush        = fl;
    runCycle();
  endtask

  task automatic checkPerf(input string tag);
    for (int i = 0; i < FU; i++) begin
`ifdef EX_WB_PERF_CNT_EN
      checkOutput(tag, 64'(bus.perf_stall_cnt[16*i +: 16]), 64'(modelStall[i]));
`else
      checkOutput(tag, 64'(bus.perf_stall_cnt[16*i +: 16]), 64'h0);
`endif
    end
  endtask

  initial begin
    testCount     = 0;
    failCount     = 0;
    stimTag       = 1;
    bus.fu_valid  = '0;
    bus.fu_data   = '0;
    bus.fu_dest   = '0;
    bus.fu_ticket = '0;
    bus.fu_exc    = '0;
    bus.fu_cause  = '0;
    clearModel();

    // Reset state.
    #12;
    checkOutput("rstWbValid", 64'(bus.wb_valid), 64'h0);
    checkOutput("rstWbData",  64'(bus.wb_data), 64'h0);
    checkOutput("rstFuReady", 64'(bus.fu_ready), 64'hF);
    checkOutput("rstPerf",    bus.perf_stall_cnt, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fairness: all four push once; FU0/FU1 leave first, then FU2/FU3.
    applyStimulus(4'hF, 1'b0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("fairValid0", 64'(bus.wb_valid), 64'h3);
    checkOutput("fairIds0",   64'(bus.wb_fu_id), 64'h4);
    applyStimulus(4'h0, 1'b0);
    checkOutput("fairValid1", 64'(bus.wb_valid), 64'h3);
    checkOutput("fairIds1",   64'(bus.wb_fu_id), 64'hE);
    applyStimulus(4'h0, 1'b0);
    checkOutput("fairIdle", 64'(bus.wb_valid), 64'h0);

    // Single push from FU2, visible two edges later on port 0.
    setFu(2, 32'hDEADBEEF, 6'd5, 3'd3, 1'b0, 4'd0);
    bus.fu_valid = 4'b0100;
    runCycle();
    bus.fu_valid = 4'b0000;
    runCycle();
    checkOutput("singleValid",  64'(bus.wb_valid), 64'h1);
    checkOutput("singleFuId",   64'(bus.wb_fu_id[1:0]), 64'h2);
    checkOutput("singleData",   64'(bus.wb_data[31:0]), 64'hDEADBEEF);
    checkOutput("singleDest",   64'(bus.wb_dest[5:0]), 64'h5);
    checkOutput("singleTicket", 64'(bus.wb_ticket[2:0]), 64'h3);
    runCycle();
    checkOutput("singleDrop",   64'(bus.wb_valid), 64'h0);
    checkOutput("singleHold",   64'(bus.wb_data[31:0]), 64'hDEADBEEF);

    // Backpressure: every FU offers a result every cycle, then drain.
    for (int c = 0; c < 100; c++) applyStimulus(4'hF, 1'b0);
    for (int c = 0; c < 12; c++)  applyStimulus(4'h0, 1'b0);
    checkOutput("drainReady", 64'(bus.fu_ready), 64'hF);
    checkPerf("perfAfterBp");

    // Flush with entries queued and a concurrent FU0 push.
    for (int c = 0; c < 3; c++) applyStimulus(4'hF, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("flushValid", 64'(bus.wb_valid), 64'h0);
    checkOutput("flushReady", 64'(bus.fu_ready), 64'hF);
    for (int c = 0; c < 4; c++) applyStimulus(4'h0, 1'b0);
    checkPerf("perfAfterFlush");

    // Reset in the middle of traffic: outputs clear without a clock edge.
    for (int c = 0; c < 3; c++) applyStimulus(4'hF, 1'b0);
    bus.fu_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(bus.wb_valid), 64'h0);
    checkOutput("midRstData",  64'(bus.wb_data), 64'h0);
    checkOutput("midRstFuId",  64'(bus.wb_fu_id), 64'h0);
    checkOutput("midRstDest",  64'(bus.wb_dest), 64'h0);
    checkOutput("midRstReady", 64'(bus.fu_ready), 64'hF);
    checkOutput("midRstPerf",  bus.perf_stall_cnt, 64'h0);
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) applyStimulus(4'h0, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(4'h0, 1'b0);
    checkPerf("perfAfterRst");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ex_wb_arbiter.md
Name: ex_wb_arbiter

Overview:
- Parametrised writeback-collection stage behind the execution functional units (LSU, CSR, ALU, BRU, plus any added FUs).
- Each FU result (fu_update) is buffered in a per-FU FIFO.
- Up to WB_PORTS results per cycle are merged round-robin onto registered writeback buses toward ROB/RF.
- Replaces the fixed, unbuffered 4-slot fu_update bundle: adds per-FU backpressure, a programmable writeback width, and flush.

Parameters:
- FU_NUMBER, 4, number of functional-unit result channels (≥2).
- WB_PORTS, 2, writeback buses per cycle (1..FU_NUMBER).
- DEPTH, 4, entries per FU FIFO (power of 2, ≥2).
- R_ADDR, 6, destination register tag width.
- ROB_INDEX_BITS, 3, ROB ticket width.
- CAUSE_W, 4, exception cause width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered and outgoing results.
- fu_valid  in  FU_NUMBER  result valid per FU.
- fu_ready  out  FU_NUMBER  FIFO can accept this cycle (count<DEPTH).
- fu_data  in  FU_NUMBER*32  result data, FU i at [32i+:32].
- fu_dest  in  FU_NUMBER*R_ADDR  destination tag.
- fu_ticket  in  FU_NUMBER*ROB_INDEX_BITS  ROB ticket.
- fu_exc  in  FU_NUMBER  exception flag.
- fu_cause  in  FU_NUMBER*CAUSE_W  exception cause.
- wb_valid  out  WB_PORTS  writeback valid.
- wb_data  out  WB_PORTS*32  writeback data.
- wb_dest  out  WB_PORTS*R_ADDR  writeback destination.
- wb_ticket  out  WB_PORTS*ROB_INDEX_BITS  writeback ROB ticket.
- wb_exc  out  WB_PORTS  exception flag.
- wb_cause  out  WB_PORTS*CAUSE_W  exception cause.
- wb_fu_id  out  WB_PORTS*$clog2(FU_NUMBER)  source FU index.
- perf_stall_cnt  out  FU_NUMBER*16  per-FU refused-push counters (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): all FIFOs empty, rr_ptr=0, all wb_* outputs 0, perf_stall_cnt 0. fu_ready is all 1 (derived from count=0).
- Push rule: FU i pushes at a clock edge iff fu_valid[i] & fu_ready[i] & ~flush.
- fu_ready[i] depends only on the current count. A full FIFO refuses a push even if it pops in the same cycle (no pass-through).
- Grant:
  - Each cycle, scan FU indices from rr_ptr upward, modulo FU_NUMBER.
  - The first WB_PORTS non-empty FIFOs are granted, in scan order, to ports 0,1,…
  - Each granted FIFO pops exactly one head entry; at most one entry per FU per cycle.
- Writeback registers:
  - Granted heads are registered into wb_* at the edge; ungranted ports get wb_valid=0 and their other fields hold the previous value.
  - Latency: push at edge t → wb_valid earliest in the cycle after edge t+1 (2 cycles).
- rr_ptr: after a cycle with ≥1 grant, rr_ptr = (last granted index + 1) mod FU_NUMBER. Unchanged when nothing is granted.
- Ordering:
  - Per-FU results leave in push order.
  - No ordering between FUs is guaranteed; the ROB reorders by ticket.
- Flush:
  - At the edge where flush=1, all FIFOs are emptied, wb_valid is cleared to 0 and rr_ptr is set to 0.
  - Pushes and grants in that cycle are discarded.
  - fu_ready is all 1 the next cycle.
- Wrap-around: FIFO read/write pointers are log2(DEPTH)+1 bits; full = MSB differs and the rest are equal.
- Reset mid-operation discards everything, same as the reset state.

Optional Feature:
- Macro EX_WB_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt[i] increments on every cycle with fu_valid[i] & ~fu_ready[i].
  - Counters saturate at 16'hFFFF.
  - Cleared only by reset, not by flush.
- Undefined: perf_stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package ex_pkg holds:
  - wb_entry_t struct: data, dest, ticket, exc, cause.
  - Default CAUSE_W.
- One sub-module, ex_wb_fifo: parametrised single-clock FIFO of wb_entry_t with push/pop/flush, count and full/empty outputs. It is instantiated FU_NUMBER times via generate.

Test Plan:
- Single push: FU2 pushes data 32'hDEADBEEF, dest 5, ticket 3 at cycle 0 → cycle 2: wb_valid=2'b01, wb_fu_id[0]=2, wb_data[0]=32'hDEADBEEF; wb_valid=0 in cycle 3.
- Fairness: all four FUs push once in cycle 0 → cycle 2: ports 0/1 carry FU0/FU1; cycle 3: FU2/FU3; rr_ptr returns to 0.
- Backpressure (DEPTH=2, WB_PORTS=1): all FUs push every cycle for 100 cycles → fu_ready[i] low exactly when count==2; scoreboard confirms no loss, no duplication, per-FU order kept.
- Flush: 3 entries queued in FU1, flush=1 with a concurrent FU0 push → next cycle wb_valid=0, fu_ready=4'hF; the FU0 entry never appears.
- Reset mid-operation: FIFOs half full, rst_n low for 1 cycle → all wb_* outputs 0 immediately (asynchronous); no stale entries after release.
- EX_WB_PERF_CNT_EN: FU3 held valid while full for 70000 cycles → perf_stall_cnt[3]=16'hFFFF. Without the macro → 0.
